// File: rtl/wb_led_fade_pkg.sv
// wb_led_fade_pkg: shared types for the LED fade block
package wb_led_fade_pkg;
   typedef enum logic [1:0] {SEL_TARGET, SEL_DIV, SEL_BUSY, SEL_NONE} reg_sel_e;
endpackage

// File: rtl/wb_led_fade.vh
// wb_led_fade.vh: register word addresses, expects CHANS to be declared first
localparam int REG_TARGET0 = 0;
localparam int REG_DIV     = CHANS;
localparam int REG_BUSY    = CHANS + 1;

// File: rtl/wb_led_fade_chan.sv
// wb_led_fade_chan: one LED channel, ramps live duty toward target and drives PWM
module wb_led_fade_chan
   import wb_led_fade_pkg::*;
#(
   parameter int PWM_BITS = 8
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                tick,
   input  logic [PWM_BITS-1:0] target,
   input  logic [PWM_BITS-1:0] cnt,
   output logic [PWM_BITS-1:0] live,
   output logic                pwm
);
   // Step one LSB toward target per tick; PWM output registered from compare
   always_ff @(posedge clk)
      if (!rst_n) begin
         live <= '0;
         pwm  <= 1'b0;
      end else begin
         if (tick && live != target) live <= live < target ? live + 1'b1 : live - 1'b1;
         pwm <= live > cnt;
      end
endmodule

// File: rtl/wb_led_fade.sv
// wb_led_fade: Wishbone-controlled multi-channel LED fader with PWM outputs
module wb_led_fade
   import wb_led_fade_pkg::*;
#(
   parameter int CHANS     = 3,
   parameter int PWM_BITS  = 8,
   parameter int DIV_BITS  = 16,
   parameter int DIV_RESET = 1000
) (
   input  logic             i_wb_clk,
   input  logic             i_wb_rst_n,
   input  logic             i_wb_stb,
   input  logic             i_wb_we,
   input  logic [31:0]      i_wb_addr,
   input  logic [31:0]      i_wb_data,
   output logic [31:0]      o_wb_data,
   output logic             o_wb_stall,
   output logic             o_wb_ack,
   output logic [CHANS-1:0] o_pwm_chan
);
   `include "wb_led_fade.vh"
   localparam int IW = CHANS > 1 ? $clog2(CHANS) : 1;
   logic [PWM_BITS-1:0] target [CHANS];
   logic [PWM_BITS-1:0] live [CHANS];
   logic [CHANS-1:0]    busy;
   logic [DIV_BITS-1:0] div, presc;
   logic [PWM_BITS-1:0] cnt;
   logic [31:0]         off, rd;
   logic [IW-1:0]       idx;
   reg_sel_e            sel;
   logic                acc, wr, tick, ack_q, unused_data;
   assign o_wb_stall  = !i_wb_rst_n;
   assign o_wb_ack    = ack_q && i_wb_rst_n;
   assign acc         = i_wb_stb && !o_wb_stall;
   assign wr          = acc && i_wb_we;
   assign tick        = presc == div;
   assign unused_data = ^i_wb_data;
   // Address decode and read-data mux; live values are read pre-tick
   always_comb begin
      off = i_wb_addr - 32'(REG_TARGET0);
      idx = off[IW-1:0];
      sel = off < 32'(CHANS) ? SEL_TARGET : i_wb_addr == 32'(REG_DIV) ? SEL_DIV :
            i_wb_addr == 32'(REG_BUSY) ? SEL_BUSY : SEL_NONE;
      rd  = sel == SEL_TARGET ? 32'(live[idx]) : sel == SEL_DIV ? 32'(div) :
            sel == SEL_BUSY ? 32'(busy) : '0;
   end
   // Bus response, divider, fade prescaler, shared PWM counter and targets
   always_ff @(posedge i_wb_clk)
      if (!i_wb_rst_n) begin
         ack_q     <= 1'b0;
         o_wb_data <= '0;
         div       <= DIV_BITS'(DIV_RESET);
         presc     <= '0;
         cnt       <= '0;
         for (int k = 0; k < CHANS; k++) target[k] <= '0;
      end else begin
         ack_q     <= acc;
         o_wb_data <= acc && !i_wb_we ? rd : '0;
         cnt       <= cnt + 1'b1;
         presc     <= tick || (wr && sel == SEL_DIV) ? '0 : presc + 1'b1;
         if (wr && sel == SEL_DIV) div <= i_wb_data[DIV_BITS-1:0];
         if (wr && sel == SEL_TARGET) target[idx] <= i_wb_data[PWM_BITS-1:0];
      end
   for (genvar c = 0; c < CHANS; c++) begin : g_chan
      wb_led_fade_chan #(.PWM_BITS(PWM_BITS)) u_chan (
         .clk    (i_wb_clk),
         .rst_n  (i_wb_rst_n),
         .tick   (tick),
         .target (target[c]),
         .cnt    (cnt),
         .live   (live[c]),
         .pwm    (o_pwm_chan[c])
      );
      assign busy[c] = live[c] != target[c];
   end
endmodule

// File: tb/tb_wb_led_fade.sv
// tb_wb_led_fade: directed scoreboard bench for wb_led_fade
module tb_wb_led_fade;
   localparam int CHANS     = 3;
   localparam int PWM_BITS  = 8;
   localparam int DIV_BITS  = 16;
   localparam int DIV_RESET = 1000;
   `include "wb_led_fade.vh"
   typedef struct {
      int          due;
      logic        chk;
      logic [31:0] exp;
      string       tag;
   } exp_t;
   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             stb = 1'b0;
   logic             we = 1'b0;
   logic [31:0]      addr = '0;
   logic [31:0]      wdata = '0;
   logic [31:0]      rdata;
   logic             stall, ack;
   logic [CHANS-1:0] pwm;
   exp_t             q[$];
   int               cyc = 0;
   int               tests = 0;
   int               fails = 0;
   int               hi0, hi1, hi2;
   wb_led_fade #(.CHANS(CHANS), .PWM_BITS(PWM_BITS), .DIV_BITS(DIV_BITS), .DIV_RESET(DIV_RESET)) dut (
      .i_wb_clk   (clk),
      .i_wb_rst_n (rst_n),
      .i_wb_stb   (stb),
      .i_wb_we    (we),
      .i_wb_addr  (addr),
      .i_wb_data  (wdata),
      .o_wb_data  (rdata),
      .o_wb_stall (stall),
      .o_wb_ack   (ack),
      .o_pwm_chan (pwm)
   );
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   // Scoreboard: every ack pops one expectation; a due entry with no ack is a miss
   always @(negedge clk) begin
      exp_t e;
      if (ack) begin
         tests++;
         assert (q.size() > 0) else begin fails++; $error("FAIL ack_unexpected: got ack=1 want no ack"); end
         if (q.size() > 0) begin
            e = q.pop_front();
            tests++;
            assert (cyc === e.due) else begin fails++; $error("FAIL %s_latency: got ack at cycle %0d want %0d", e.tag, cyc, e.due); end
            if (e.chk) begin
               tests++;
               assert (rdata === e.exp) else begin fails++; $error("FAIL %s: got %0d want %0d", e.tag, rdata, e.exp); end
            end
         end
      end else if (q.size() > 0 && q[0].due <= cyc) begin
         e = q.pop_front();
         tests++;
         assert (1'b0) else begin fails++; $error("FAIL %s_ack: got no ack want ack at cycle %0d", e.tag, e.due); end
      end
   end
   task automatic req(input logic w, input int a, input int d, input logic chk, input int exp, input string tag);
      stb = 1'b1; we = w; addr = 32'(a); wdata = 32'(d);
      q.push_back('{due: cyc + 1, chk: chk, exp: 32'(exp), tag: tag});
      @(negedge clk);
      stb = 1'b0;
   endtask
   task automatic count_pwm(output int c0, output int c1, output int c2);
      c0 = 0; c1 = 0; c2 = 0;
      repeat (256) begin
         @(negedge clk);
         c0 += int'(pwm[0]); c1 += int'(pwm[1]); c2 += int'(pwm[2]);
      end
   endtask
   initial begin
      // reset held three cycles
      repeat (3) begin
         @(negedge clk);
         tests += 3;
         assert (stall === 1'b1) else begin fails++; $error("FAIL rst_stall: got %b want 1", stall); end
         assert (ack === 1'b0) else begin fails++; $error("FAIL rst_ack: got %b want 0", ack); end
         assert (pwm === '0) else begin fails++; $error("FAIL rst_pwm: got %b want 0", pwm); end
      end
      rst_n = 1'b1;
      #1;
      tests++;
      assert (stall === 1'b0) else begin fails++; $error("FAIL stall_release: got %b want 0", stall); end
      @(negedge clk);
      req(1'b0, REG_DIV, 0, 1'b1, DIV_RESET, "div_reset");
      // ramp target0 to 4 with a tick every cycle; reads return pre-tick value
      req(1'b1, REG_DIV, 0, 1'b0, 0, "w_div0");
      req(1'b1, REG_TARGET0, 4, 1'b0, 0, "w_t0");
      for (int j = 0; j < 6; j++) req(1'b0, REG_TARGET0, 0, 1'b1, j < 4 ? j : 4, "ramp_up");
      req(1'b1, REG_TARGET0, 6, 1'b0, 0, "w_t0_6");
      req(1'b0, REG_BUSY, 0, 1'b1, 1, "busy_set");
      req(1'b0, REG_TARGET0, 0, 1'b1, 5, "live0_5");
      req(1'b0, REG_BUSY, 0, 1'b1, 0, "busy_clr");
      req(1'b0, REG_TARGET0, 0, 1'b1, 6, "live0_6");
      // back-to-back mixed requests, unmapped address, ignored writes
      req(1'b1, REG_TARGET0 + 1, 9, 1'b0, 0, "w_t1");
      req(1'b0, REG_TARGET0 + 1, 0, 1'b1, 0, "live1_pre");
      req(1'b0, 99, 0, 1'b1, 0, "rd_unmapped");
      req(1'b1, 99, 32'h55, 1'b0, 0, "w_unmapped");
      req(1'b1, REG_BUSY, 32'hff, 1'b0, 0, "w_busy");
      req(1'b0, REG_BUSY, 0, 1'b1, 2, "busy_ch1");
      repeat (12) @(negedge clk);
      req(1'b0, REG_TARGET0 + 1, 0, 1'b1, 9, "live1_9");
      req(1'b0, REG_BUSY, 0, 1'b1, 0, "busy_idle");
      req(1'b0, REG_DIV, 0, 1'b1, 0, "div_kept");
      // mid-ramp reversal: 40 up-steps from 9 to peak 49, then down to 10
      req(1'b1, REG_TARGET0 + 1, 200, 1'b0, 0, "w_t1_200");
      repeat (39) @(negedge clk);
      req(1'b1, REG_TARGET0 + 1, 10, 1'b0, 0, "w_t1_10");
      for (int j = 1; j <= 45; j++) req(1'b0, REG_TARGET0 + 1, 0, 1'b1, 50 - j > 10 ? 50 - j : 10, "reverse");
      // divider 2: a tick every third cycle after the divider write
      req(1'b1, REG_DIV, 2, 1'b0, 0, "w_div2");
      req(1'b1, REG_TARGET0, 0, 1'b0, 0, "w_t0_0");
      for (int j = 2; j <= 10; j++) req(1'b0, REG_TARGET0, 0, 1'b1, 6 - (j - 1) / 3, "slow_fade");
      req(1'b1, REG_DIV, 0, 1'b0, 0, "w_div0b");
      // PWM duty counts over a full counter period
      req(1'b1, REG_TARGET0 + 2, 64, 1'b0, 0, "w_t2_64");
      repeat (80) @(negedge clk);
      count_pwm(hi0, hi1, hi2);
      tests += 3;
      assert (hi2 === 64) else begin fails++; $error("FAIL pwm2_64: got %0d want 64", hi2); end
      assert (hi1 === 10) else begin fails++; $error("FAIL pwm1_10: got %0d want 10", hi1); end
      assert (hi0 === 0) else begin fails++; $error("FAIL pwm0_0: got %0d want 0", hi0); end
      req(1'b1, REG_TARGET0 + 2, 0, 1'b0, 0, "w_t2_0");
      repeat (80) @(negedge clk);
      count_pwm(hi0, hi1, hi2);
      tests++;
      assert (hi2 === 0) else begin fails++; $error("FAIL pwm2_off: got %0d want 0", hi2); end
      // reset during the ack cycle of an accepted write
      stb = 1'b1; we = 1'b1; addr = 32'(REG_TARGET0); wdata = 32'd77;
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      stb = 1'b0;
      @(negedge clk);
      tests += 2;
      assert (ack === 1'b0) else begin fails++; $error("FAIL rst_drop_ack: got %b want 0", ack); end
      assert (stall === 1'b1) else begin fails++; $error("FAIL rst_stall2: got %b want 1", stall); end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      for (int j = 0; j < CHANS; j++) req(1'b0, REG_TARGET0 + j, 0, 1'b1, 0, "live_after_rst");
      req(1'b0, REG_BUSY, 0, 1'b1, 0, "busy_after_rst");
      req(1'b0, REG_DIV, 0, 1'b1, DIV_RESET, "div_after_rst");
      for (int j = 0; j < 10 && q.size() > 0; j++) @(negedge clk);
      tests++;
      assert (q.size() === 0) else begin fails++; $error("FAIL drain: got %0d pending want 0", q.size()); end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
